// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: time-shares one external full_adder cell over WIDTH bits, LSB first.
// Optional signed-overflow output is enabled by defining SERIAL_ADD_OVF_EN.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
`ifdef SERIAL_ADD_OVF_EN
  output logic             ovf,
`endif
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_cin,
  input  logic             fa_s,
  input  logic             fa_cout
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  // Bit 0 of each operand goes straight into fa_a/fa_b, so only the upper bits are kept here.
  logic [WIDTH-2:0] a_sh_r;
  logic [WIDTH-2:0] b_sh_r;
  logic [WIDTH-2:0] sum_sh_r;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] sum_nxt_s;
  logic             last_s;

  assign sum_nxt_s = {fa_s, sum_sh_r};
  assign last_s    = (cnt_r == CW'(WIDTH - 1));

  // Sequencer FSM; fa_cin doubles as the running carry flop and every output is registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      a_sh_r   <= {(WIDTH-1){1'b0}};
      b_sh_r   <= {(WIDTH-1){1'b0}};
      sum_sh_r <= {(WIDTH-1){1'b0}};
      cnt_r    <= {CW{1'b0}};
      busy     <= 1'b0;
      done     <= 1'b0;
      sum      <= {WIDTH{1'b0}};
      cout     <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf      <= 1'b0;
`endif
      fa_a     <= 1'b0;
      fa_b     <= 1'b0;
      fa_cin   <= 1'b0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            state_r  <= RUN;
            busy     <= 1'b1;
            a_sh_r   <= a[WIDTH-1:1];
            b_sh_r   <= b[WIDTH-1:1];
            sum_sh_r <= {(WIDTH-1){1'b0}};
            cnt_r    <= {CW{1'b0}};
            fa_a     <= a[0];
            fa_b     <= b[0];
            fa_cin   <= cin;
          end else begin
            state_r  <= IDLE;
          end
        end
        RUN: begin
          cnt_r    <= cnt_r + CW'(1);
          sum_sh_r <= sum_nxt_s[WIDTH-1:1];
          a_sh_r   <= a_sh_r >> 1'b1;
          b_sh_r   <= b_sh_r >> 1'b1;
          fa_a     <= a_sh_r[0];
          fa_b     <= b_sh_r[0];
          fa_cin   <= fa_cout;
          if (last_s) begin
            state_r <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            sum     <= sum_nxt_s;
            cout    <= fa_cout;
`ifdef SERIAL_ADD_OVF_EN
            // fa_cin still holds the carry into the MSB on this edge.
            ovf     <= fa_cin ^ fa_cout;
`endif
            fa_a    <= 1'b0;
            fa_b    <= 1'b0;
            fa_cin  <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
          fa_a    <= 1'b0;
          fa_b    <= 1'b0;
          fa_cin  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Bit-serial addition sequencer that time-shares one external `full_adder` cell across a WIDTH-bit operand pair.
- Latches operands on `start` and drives the cell one bit per clock, LSB first, holding the running carry in a flop.
- Collects sum bits and presents the WIDTH-bit result plus carry-out with a one-cycle `done` pulse.
- Sits between a requesting datapath and a single shared `full_adder` instance; area-optimised alternative to a ripple adder.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
- `clk`  input  1  single system clock, rising-edge.
- `rst_n`  input  1  asynchronous active-low reset.
- `start`  input  1  request; sampled on rising edge of `clk`.
- `a`  input  WIDTH  operand A; sampled only when `start` is accepted.
- `b`  input  WIDTH  operand B; sampled only when `start` is accepted.
- `cin`  input  1  initial carry-in; sampled only when `start` is accepted.
- `busy`  output  1  high while bits are being processed.
- `done`  output  1  one-cycle pulse; result is valid from this cycle on.
- `sum`  output  WIDTH  result; held until the next `done`.
- `cout`  output  1  final carry-out; held until the next `done`.
- `fa_a`  output  1  to the `full_adder` `a` input.
- `fa_b`  output  1  to the `full_adder` `b` input.
- `fa_cin`  output  1  to the `full_adder` `cin` input.
- `fa_s`  input  1  from the `full_adder` `s` output.
- `fa_cout`  input  1  from the `full_adder` `cout` output.

Behaviour:
- Clock and reset: one clock `clk`; reset `rst_n` is asynchronous, active-low.
- Reset values: state=IDLE; `busy`=0, `done`=0, `sum`=0, `cout`=0; `fa_a`/`fa_b`/`fa_cin`=0; internal shift registers, carry flop and bit counter all 0.
- States are IDLE, RUN and DONE.
- IDLE: on an edge with `start`=1, latch `a`→`a_sh` and `b`→`b_sh`, load `cin` into the carry flop, set counter=0, then go to RUN. `start`=0 keeps the block in IDLE.
- RUN:
  - Combinational drive: `fa_a`=`a_sh`[0], `fa_b`=`b_sh`[0], `fa_cin`=carry flop.
  - Each edge: `a_sh`/`b_sh` shift right by 1; `fa_s` shifts into the MSB of the sum shift register; carry flop takes `fa_cout`; counter increments.
  - On the edge where counter==WIDTH-1: copy the completed sum into `sum`, copy `fa_cout` into `cout`, then go to DONE.
- DONE: `done`=1 for exactly this cycle. On the next edge, `start`=1 is accepted exactly as in IDLE (back-to-back operation, goes straight to RUN); otherwise go to IDLE.
- Outside RUN, `fa_*` outputs are driven to 0.
- `busy` = (state==RUN), decoded combinationally from the state register.
- Latency: the edge that accepts `start` is edge 0. RUN spans edges 1..WIDTH. `done` is high in the cycle after edge WIDTH. Issue interval is WIDTH+1 cycles.
- `start` while in RUN is ignored and not queued; `a`, `b` and `cin` may change freely during RUN.
- `sum` and `cout` change only on entry to DONE and are stable otherwise.
- Reset asserted mid-RUN: immediate abort to the reset values; no `done` is produced; the partial result is discarded.
- The external `full_adder` is purely combinational. Its path `fa_*` out → `fa_s`/`fa_cout` in must close in one cycle; it is not registered here.

Optional Feature:
- Macro: `SERIAL_ADD_OVF_EN`.
- Defined:
  - Extra output port `ovf` (1 bit), signed two's-complement overflow.
  - `ovf` = (carry into MSB) XOR (final carry-out), i.e. the carry flop value XOR `fa_cout` on the last RUN edge.
  - Updated together with `sum`; reset value 0.
- Undefined: no `ovf` port and no associated logic.

Test Plan:
- WIDTH=8, `a`=0x5A, `b`=0x3C, `cin`=0, pulse `start` → `busy` high for 8 cycles; `done` on cycle 9 after the accept edge; `sum`=0x96, `cout`=0; `ovf`=1 if enabled.
- `a`=0xFF, `b`=0x01, `cin`=0 → `sum`=0x00, `cout`=1, `ovf`=0. Also `a`=0xFF, `b`=0x00, `cin`=1 → `sum`=0x00, `cout`=1.
- Start `a`=0x12, `b`=0x34; pulse `start` again at RUN cycle 3 with `a`=0xFF → ignored; `sum`=0x46; exactly one `done`.
- Hold `start` high continuously with 0x01+0x01 → a `done` every 9 cycles; `sum`=0x02 each time; `busy` low only in `done` cycles.
- Assert `rst_n`=0 at RUN cycle 4 of 0x80+0x80 → all outputs 0 asynchronously; after release, no `done` until a new `start`; a following 0x80+0x80 gives `sum`=0x00, `cout`=1, `ovf`=1.
- Check `fa_a`/`fa_b` against operand bit i in RUN cycle i for 0xA5+0x5A, and `fa_*`=0 in IDLE and DONE → `sum`=0xFF, `cout`=0.
